uart_bus_master: RTL
====================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter DIVIDER, default 24, meaning clocks per serial bit minus one; bit period = DIVIDER+1 clocks.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum wait in clocks for ack_i before a bus cycle is aborted.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rxd  in  1  serial command input, idle high.
REQ-006 SHALL have port txd  out  1  serial response output, idle high.
REQ-007 SHALL have port adr_o  out  32  bus address.
REQ-008 SHALL have port dat_o  out  32  bus write data.
REQ-009 SHALL have port dat_i  in  32  bus read data.
REQ-010 SHALL have port sel_o  out  4  byte selects.
REQ-011 SHALL have port we_o  out  1  write enable.
REQ-012 SHALL have port stb_o  out  1  bus strobe.
REQ-013 SHALL have port ack_i  in  1  responder acknowledge.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer, both flops preset to 1, before any use.
REQ-015 RX SHALL detect a start bit on a low synchronized rxd while RX is idle.
REQ-016 RX SHALL sample at 50% of each bit period: load bit counter with DIVIDER>>1, then sample every DIVIDER+1 clocks.
REQ-017 RX SHALL abort silently if the start-bit sample is high (glitch).
REQ-018 RX SHALL shift 8 data bits LSB first.
REQ-019 RX SHALL deliver the byte only if the stop-bit sample is 1, and SHALL discard it otherwise.
REQ-020 TX SHALL send a 10-bit frame: 0, data[0..7], 1, each bit held DIVIDER+1 clocks.
REQ-021 Frames SHALL be sent back-to-back with no gap, and txd SHALL be 1 when TX is idle.
REQ-022 Command protocol: 0x57 'W' + 4 address bytes + 4 data bytes performs a 32-bit write.
REQ-023 Command protocol: 0x52 'R' + 4 address bytes performs a 32-bit read.
REQ-024 Multi-byte address and data fields SHALL be MSB first.
REQ-025 Any other byte received in IDLE SHALL be ignored.
REQ-026 FSM states SHALL be IDLE, ADDR (count 0-3), WDATA (count 0-3), BUS, RDLAT, RESP.
REQ-027 Transitions: IDLE->ADDR on 'R'/'W'; ADDR->WDATA after 4 bytes if write, ADDR->BUS if read; WDATA->BUS after 4 bytes.
REQ-028 Transitions: BUS->RDLAT on ack for read; BUS->RESP on ack for write or on timeout; RDLAT->RESP after 1 clock; RESP->IDLE when the last response byte has left txd (stop bit complete).
REQ-029 On entry to BUS: stb_o=1, sel_o=4'b1111, we_o=1 for write / 0 for read, and adr_o/dat_o SHALL stay stable until stb_o drops.
REQ-030 stb_o SHALL drop on the clock after ack_i is sampled high, so the strobe lasts at least one clock.
REQ-031 Read data SHALL be captured from dat_i in RDLAT, i.e. the clock after ack, to suit registered-read responders.
REQ-032 A 9-bit wait counter SHALL clear on BUS entry; if it reaches TIMEOUT with no ack, stb_o SHALL drop next clock and the response SHALL be 0x45 'E'.
REQ-033 Responses: write acked -> 0x4B 'K'; read acked -> 4 data bytes MSB first; timeout -> 'E' (read or write).
REQ-034 Bytes received in BUS, RDLAT or RESP SHALL be dropped; the frame parser SHALL restart only in IDLE.
REQ-035 ack_i while stb_o=0 SHALL be ignored.

Reset
REQ-036 rst_i SHALL force at the next edge: FSM IDLE, RX/TX idle, txd=1, stb_o=0, we_o=0, sel_o=0, adr_o=0, dat_o=0, and all counters 0.
REQ-037 Reset mid-frame or mid-bus-cycle SHALL abandon the operation with no response byte, and stb_o SHALL be low the clock after reset is sampled.

Verification
REQ-038 DIVIDER=3: send 'W',00,00,00,10,DE,AD,BE,EF; responder acks in 2 clocks -> one stb_o pulse, adr_o=0x00000010, dat_o=0xDEADBEEF, we_o=1, sel_o=F; txd sends 0x4B.
REQ-039 Read 0x00000004, responder returns 0x12345678 the cycle after ack -> txd sends 12,34,56,78 back-to-back, 40 bits with no idle gap; we_o=0.
REQ-040 ack_i held low, TIMEOUT=15 -> stb_o high exactly 16 clocks then low; txd sends 0x45; FSM returns to IDLE.
REQ-041 Bytes 0x00,0xFF,0x41, then 1-clock rxd glitch low, then a valid 'R' frame -> only the read executes; no response to the junk bytes.
REQ-042 Byte with stop bit 0 inside an address field -> byte discarded; the next valid byte is taken as the same address byte index.
REQ-043 Assert rst_i while stb_o=1 and during a response frame -> stb_o=0 and txd=1 next clock; a new 'W' frame then completes normally.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART command port driving a single-master 32-bit bus.
// 'W' + addr[4] + data[4] writes and answers 'K'; 'R' + addr[4] reads and
// answers with the four data bytes. A bus timeout answers 'E'.
// All multi-byte fields are MSB first.
module uart_bus_master #(
    parameter int unsigned DIVIDER = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        stb_o,
    input  logic        ack_i
);

    localparam int unsigned CntW = (DIVIDER < 1) ? 1 : $clog2(DIVIDER + 1);
    localparam logic [CntW-1:0] BitLast = CntW'(DIVIDER);
    localparam logic [CntW-1:0] BitHalf = CntW'(DIVIDER >> 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [8:0]      WaitLast = 9'(TIMEOUT);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RespOk   = 8'h4B;
    localparam logic [7:0] RespErr  = 8'h45;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxSend} tx_state_e;
    typedef enum logic [2:0] {StIdle, StAddr, StWdata, StBus, StRdlat, StResp} state_e;

    // ---------------------------------------------------------------------
    // rxd synchronizer
    // ---------------------------------------------------------------------
    logic rxd_meta_q, rxd_sync_q;

    // Two-flop synchronizer, preset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // ---------------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------------
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Receiver next state: mid-bit sampling, glitch rejection, stop-bit check.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rxd_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = BitHalf;
                end
            end
            RxStart: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end else if (rxd_sync_q) begin
                    rx_state_d = RxIdle;
                end else begin
                    rx_state_d = RxData;
                    rx_cnt_d   = BitLast;
                    rx_bit_d   = '0;
                end
            end
            RxData: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end else begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BitLast;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RxStop: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end else begin
                    rx_state_d = RxIdle;
                    // A low stop bit is a framing error: drop the byte.
                    rx_valid_d = rxd_sync_q;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic            tx_ready;
    logic            tx_load;
    logic [7:0]      tx_byte;

    // Ready while idle and also in the final clock of a stop bit, so the next
    // frame can start with no gap.
    assign tx_ready = (tx_state_q == TxIdle) || ((tx_cnt_q == '0) && (tx_bit_q == 4'd9));
    assign txd      = (tx_state_q == TxSend) ? tx_shift_q[0] : 1'b1;

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Transmitter next state: load a 10-bit frame, shift one bit per period.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_load) begin
            tx_state_d = TxSend;
            tx_shift_d = {1'b1, tx_byte, 1'b0};
            tx_cnt_d   = BitLast;
            tx_bit_d   = '0;
        end else if (tx_state_q == TxSend) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_d = tx_cnt_q - CntOne;
            end else if (tx_bit_q == 4'd9) begin
                tx_state_d = TxIdle;
            end else begin
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_cnt_d   = BitLast;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Command FSM and bus master
    // ---------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [8:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] resp_buf_q, resp_buf_d;
    logic [2:0]  resp_left_q, resp_left_d;

    assign adr_o = adr_q;
    assign dat_o = wdat_q;
    assign sel_o = sel_q;
    assign we_o  = we_q;
    assign stb_o = stb_q;

    // Command FSM and bus register state.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            is_write_q  <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wait_cnt_q  <= '0;
            resp_buf_q  <= '0;
            resp_left_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            is_write_q  <= is_write_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wait_cnt_q  <= wait_cnt_d;
            resp_buf_q  <= resp_buf_d;
            resp_left_q <= resp_left_d;
        end
    end

    // Command parsing, bus cycle with timeout, and response sequencing.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        is_write_d  = is_write_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wait_cnt_d  = wait_cnt_q;
        resp_buf_d  = resp_buf_q;
        resp_left_d = resp_left_q;
        tx_load     = 1'b0;
        tx_byte     = resp_buf_q[31:24];
        unique case (state_q)
            StIdle: begin
                if (rx_valid_q && ((rx_shift_q == CmdWrite) || (rx_shift_q == CmdRead))) begin
                    state_d    = StAddr;
                    is_write_d = (rx_shift_q == CmdWrite);
                    byte_cnt_d = '0;
                end
            end
            StAddr: begin
                if (rx_valid_q) begin
                    adr_d = {adr_q[23:0], rx_shift_q};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        if (is_write_q) begin
                            state_d = StWdata;
                        end else begin
                            state_d    = StBus;
                            stb_d      = 1'b1;
                            sel_d      = 4'b1111;
                            we_d       = 1'b0;
                            wait_cnt_d = '0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StWdata: begin
                if (rx_valid_q) begin
                    wdat_d = {wdat_q[23:0], rx_shift_q};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        state_d    = StBus;
                        stb_d      = 1'b1;
                        sel_d      = 4'b1111;
                        we_d       = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StBus: begin
                if (ack_i) begin
                    stb_d = 1'b0;
                    sel_d = '0;
                    we_d  = 1'b0;
                    if (is_write_q) begin
                        state_d     = StResp;
                        resp_buf_d  = {RespOk, 24'h0};
                        resp_left_d = 3'd1;
                    end else begin
                        state_d = StRdlat;
                    end
                end else if (wait_cnt_q == WaitLast) begin
                    stb_d       = 1'b0;
                    sel_d       = '0;
                    we_d        = 1'b0;
                    state_d     = StResp;
                    resp_buf_d  = {RespErr, 24'h0};
                    resp_left_d = 3'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 9'd1;
                end
            end
            StRdlat: begin
                // Responder presents read data the clock after its ack.
                resp_buf_d  = dat_i;
                resp_left_d = 3'd4;
                state_d     = StResp;
            end
            StResp: begin
                if (resp_left_q != '0) begin
                    if (tx_ready) begin
                        tx_load     = 1'b1;
                        resp_buf_d  = {resp_buf_q[23:0], 8'h00};
                        resp_left_d = resp_left_q - 3'd1;
                    end
                end else if (tx_state_q == TxIdle) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
